// File: rtl/configure.sv
// Shared memory-bus types, reset values, address map and router state encoding.
package configure;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic        mem_error;
        logic [31:0] mem_rdata;
    } mem_out_type;

    localparam mem_in_type  init_mem_in  = '0;
    localparam mem_out_type init_mem_out = '0;

    localparam logic [31:0] rom_base_addr   = 32'h0000_0000;
    localparam logic [31:0] rom_mask_addr   = 32'h0000_FFFF;
    localparam logic [31:0] ram_base_addr   = 32'h0010_0000;
    localparam logic [31:0] ram_mask_addr   = 32'h000F_FFFF;
    localparam logic [31:0] tim_base_addr   = 32'h0020_0000;
    localparam logic [31:0] tim_mask_addr   = 32'h0000_0FFF;
    localparam logic [31:0] qspi_base_addr  = 32'h0030_0000;
    localparam logic [31:0] qspi_mask_addr  = 32'h000F_FFFF;
    localparam logic [31:0] clint_base_addr = 32'h0200_0000;
    localparam logic [31:0] clint_mask_addr = 32'h0000_FFFF;
    localparam logic [31:0] uart_base_addr  = 32'h1000_0000;
    localparam logic [31:0] uart_mask_addr  = 32'h0000_0FFF;

    localparam int rom_idx   = 0;
    localparam int ram_idx   = 1;
    localparam int tim_idx   = 2;
    localparam int qspi_idx  = 3;
    localparam int clint_idx = 4;
    localparam int uart_idx  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        ERR  = 2'd3
    } router_state_type;

endpackage

// File: rtl/mem_router_decode.sv
// Base/mask address decode over NSLV entries; purely combinational.
// Lowest matching index wins when windows overlap.
module mem_router_decode
    import configure::*;
#(
    parameter int                      NSLV      = 8,
    parameter int                      SW        = 3,
    parameter logic [NSLV-1:0][31:0]   BASE_ADDR = '0,
    parameter logic [NSLV-1:0][31:0]   MASK_ADDR = '0
) (
    input  logic [31:0]   addr,
    output logic          hit,
    output logic [SW-1:0] sel
);

    always_comb begin
        hit = 1'b0;
        sel = '0;
        // Walk downward so the lowest index is the last (winning) assignment.
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (~|(BASE_ADDR[i] ^ (addr & ~MASK_ADDR[i]))) begin
                hit = 1'b1;
                sel = SW'(i);
            end
        end
    end

endmodule

// File: rtl/mem_router.sv
// Single-master to NSLV-slave router with one outstanding transaction,
// decode-miss error response, per-transaction timeout and sticky protocol-error flag.
module mem_router
    import configure::*;
#(
    parameter int                      NSLV      = 8,
    parameter logic [NSLV-1:0][31:0]   BASE_ADDR = '0,
    parameter logic [NSLV-1:0][31:0]   MASK_ADDR = '0,
    parameter bit                      RELATIVE  = 1'b1,
    parameter int                      TIMEOUT   = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  mst_in,
    output mem_out_type mst_out,
    output mem_in_type  slv_in [NSLV],
    input  mem_out_type slv_out [NSLV],
    output logic        busy,
    output logic        timeout_err,
    output logic        proto_err
);

    localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    router_state_type state_q, state_d;
    logic [SW-1:0]    sel_q, sel_d;
    mem_in_type       req_q, req_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             to_q, to_d;
    logic             proto_q, proto_d;

    logic             dec_hit;
    logic [SW-1:0]    dec_sel;

    mem_router_decode #(
        .NSLV      (NSLV),
        .SW        (SW),
        .BASE_ADDR (BASE_ADDR),
        .MASK_ADDR (MASK_ADDR)
    ) u_decode (
        .addr (mst_in.mem_addr),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
        // Requests are not queued: any valid outside IDLE is dropped and flagged.
        proto_d = proto_q | (mst_in.mem_valid & (state_q != IDLE));
        mst_out = init_mem_out;
        for (int i = 0; i < NSLV; i++) begin
            slv_in[i] = init_mem_in;
        end

        case (state_q)
            IDLE: begin
                if (mst_in.mem_valid) begin
                    req_d           = mst_in;
                    req_d.mem_valid = 1'b1;
                    sel_d           = dec_sel;
                    if (RELATIVE) begin
                        req_d.mem_addr = mst_in.mem_addr - BASE_ADDR[dec_sel];
                    end
                    state_d = dec_hit ? REQ : ERR;
                end
            end
            REQ: begin
                slv_in[sel_q] = req_q;
                cnt_d         = '0;
                state_d       = WAIT;
            end
            WAIT: begin
                // Only the selected slave can complete; ready beats expiry in the same cycle.
                if (slv_out[sel_q].mem_ready) begin
                    mst_out = slv_out[sel_q];
                    state_d = IDLE;
                end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
                    to_d    = 1'b1;
                    state_d = ERR;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ERR: begin
                mst_out.mem_ready = 1'b1;
                mst_out.mem_error = 1'b1;
                mst_out.mem_rdata = '0;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            req_q   <= init_mem_in;
            cnt_q   <= '0;
            to_q    <= 1'b0;
            proto_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            proto_q <= proto_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign timeout_err = to_q;
    assign proto_err   = proto_q;

endmodule

// File: tb/tb_mem_router.sv
// Directed bench for mem_router: 4 slaves on 64 KiB windows, timeout of 16 cycles.
module tb_mem_router;
    import configure::*;

    logic        clock = 1'b0;
    logic        reset;
    mem_in_type  mst_in;
    mem_out_type mst_out;
    mem_in_type  slv_in [4];
    mem_out_type slv_out [4];
    logic        busy;
    logic        timeout_err;
    logic        proto_err;

    int n_checks = 0;
    int n_errors = 0;
    int early;

    always #5 clock = ~clock;

    mem_router #(
        .NSLV      (4),
        .BASE_ADDR ({32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000}),
        .MASK_ADDR ({4{32'h0000_FFFF}}),
        .RELATIVE  (1'b1),
        .TIMEOUT   (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mst_in      (mst_in),
        .mst_out     (mst_out),
        .slv_in      (slv_in),
        .slv_out     (slv_out),
        .busy        (busy),
        .timeout_err (timeout_err),
        .proto_err   (proto_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic [31:0] addr);
        mst_in           = init_mem_in;
        mst_in.mem_valid = 1'b1;
        mst_in.mem_addr  = addr;
    endtask

    task automatic clear_bus();
        mst_in = init_mem_in;
        for (int i = 0; i < 4; i++) slv_out[i] = init_mem_out;
    endtask

    function automatic logic [31:0] slv_valids();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) v[i] = slv_in[i].mem_valid;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        clear_bus();
        repeat (3) cyc();
        settle();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mst_ready", 32'(mst_out.mem_ready), 32'd0);
        check("rst_slv_valid", slv_valids(), 32'h0);
        check("rst_proto", 32'(proto_err), 32'd0);
        check("rst_tmo", 32'(timeout_err), 32'd0);
        reset = 1'b1;

        // 1: hit on slave1, ready 3 cycles after the request cycle
        cyc(); issue(32'h0001_0004); settle();
        check("t1_idle_busy", 32'(busy), 32'd0);
        cyc(); clear_bus(); settle();
        check("t1_req_valids", slv_valids(), 32'h2);
        check("t1_req_addr", slv_in[1].mem_addr, 32'h4);
        check("t1_req_busy", 32'(busy), 32'd1);
        cyc(); settle();
        check("t1_wait_valids", slv_valids(), 32'h0);
        check("t1_wait_noresp", 32'(mst_out.mem_ready), 32'd0);
        cyc(); settle();
        cyc(); slv_out[1].mem_ready = 1'b1; slv_out[1].mem_rdata = 32'hCAFE; settle();
        check("t1_resp_ready", 32'(mst_out.mem_ready), 32'd1);
        check("t1_resp_rdata", mst_out.mem_rdata, 32'hCAFE);
        check("t1_resp_error", 32'(mst_out.mem_error), 32'd0);
        cyc(); clear_bus(); settle();
        check("t1_done_busy", 32'(busy), 32'd0);
        check("t1_done_ready", 32'(mst_out.mem_ready), 32'd0);

        // 2: decode miss
        cyc(); issue(32'h0009_0000); settle();
        cyc(); clear_bus(); settle();
        check("t2_err_ready", 32'(mst_out.mem_ready), 32'd1);
        check("t2_err_error", 32'(mst_out.mem_error), 32'd1);
        check("t2_err_rdata", mst_out.mem_rdata, 32'h0);
        check("t2_no_slv_valid", slv_valids(), 32'h0);
        check("t2_no_tmo", 32'(timeout_err), 32'd0);
        cyc(); settle();
        check("t2_after_ready", 32'(mst_out.mem_ready), 32'd0);
        check("t2_after_busy", 32'(busy), 32'd0);

        // 3: slave2 never answers
        cyc(); issue(32'h0002_0000); settle();
        cyc(); clear_bus(); settle();
        check("t3_req_valids", slv_valids(), 32'h4);
        early = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(); settle();
            if (mst_out.mem_ready) early++;
        end
        check("t3_no_early_resp", 32'(early), 32'd0);
        cyc(); settle();
        check("t3_tmo_ready", 32'(mst_out.mem_ready), 32'd1);
        check("t3_tmo_error", 32'(mst_out.mem_error), 32'd1);
        check("t3_tmo_pulse", 32'(timeout_err), 32'd1);
        cyc(); slv_out[2].mem_ready = 1'b1; slv_out[2].mem_rdata = 32'hDEAD; settle();
        check("t3_late_ignored", 32'(mst_out.mem_ready), 32'd0);
        check("t3_tmo_cleared", 32'(timeout_err), 32'd0);
        check("t3_late_busy", 32'(busy), 32'd0);

        // 4: spurious ready from slave0 while slave3 is selected
        cyc(); clear_bus(); issue(32'h0003_0008); settle();
        cyc(); clear_bus(); settle();
        check("t4_req_valids", slv_valids(), 32'h8);
        check("t4_req_addr", slv_in[3].mem_addr, 32'h8);
        cyc(); slv_out[0].mem_ready = 1'b1; slv_out[0].mem_rdata = 32'hBAD; settle();
        check("t4_spurious_blocked", 32'(mst_out.mem_ready), 32'd0);
        cyc(); clear_bus(); slv_out[3].mem_ready = 1'b1; slv_out[3].mem_rdata = 32'h1234; settle();
        check("t4_resp_ready", 32'(mst_out.mem_ready), 32'd1);
        check("t4_resp_rdata", mst_out.mem_rdata, 32'h1234);
        cyc(); clear_bus(); settle();
        check("t4_done_busy", 32'(busy), 32'd0);

        // 5: valid while busy is dropped and flagged
        cyc(); issue(32'h0001_0010); settle();
        cyc(); issue(32'h0002_0000); settle();
        check("t5_req_addr", slv_in[1].mem_addr, 32'h10);
        check("t5_proto_not_yet", 32'(proto_err), 32'd0);
        cyc(); clear_bus(); settle();
        check("t5_proto_set", 32'(proto_err), 32'd1);
        check("t5_dropped", slv_valids(), 32'h0);
        cyc(); slv_out[1].mem_ready = 1'b1; slv_out[1].mem_rdata = 32'h55; settle();
        check("t5_resp_ready", 32'(mst_out.mem_ready), 32'd1);
        check("t5_resp_rdata", mst_out.mem_rdata, 32'h55);
        cyc(); clear_bus(); settle();
        check("t5_done_busy", 32'(busy), 32'd0);
        check("t5_proto_sticky", 32'(proto_err), 32'd1);

        // 6: reset mid-transaction
        cyc(); issue(32'h0001_0000); settle();
        cyc(); clear_bus(); settle();
        cyc(); reset = 1'b0; settle();
        cyc(); reset = 1'b1; slv_out[1].mem_ready = 1'b1; slv_out[1].mem_rdata = 32'h77; settle();
        check("t6_busy_clear", 32'(busy), 32'd0);
        check("t6_stale_ignored", 32'(mst_out.mem_ready), 32'd0);
        check("t6_proto_reset", 32'(proto_err), 32'd0);
        cyc(); clear_bus(); issue(32'h0001_0020); settle();
        cyc(); clear_bus(); settle();
        check("t6_req_valids", slv_valids(), 32'h2);
        check("t6_req_addr", slv_in[1].mem_addr, 32'h20);
        cyc(); slv_out[1].mem_ready = 1'b1; slv_out[1].mem_rdata = 32'hABCD; settle();
        check("t6_resp_ready", 32'(mst_out.mem_ready), 32'd1);
        check("t6_resp_rdata", mst_out.mem_rdata, 32'hABCD);
        cyc(); clear_bus(); settle();
        check("t6_done_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
